// File: rtl/sdi_rx_axil_regs_if.sv
// AXI4-Lite bus bundle between the SDI RX register bank and its bus master.
// Signal names follow the AXI S00_AXI port naming.
interface sdi_rx_axil_regs_if #(
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned DataWidth = 32
);
  logic [AddrWidth-1:0]   S_AXI_AWADDR;
  logic [2:0]             S_AXI_AWPROT;
  logic                   S_AXI_AWVALID;
  logic                   S_AXI_AWREADY;
  logic [DataWidth-1:0]   S_AXI_WDATA;
  logic [DataWidth/8-1:0] S_AXI_WSTRB;
  logic                   S_AXI_WVALID;
  logic                   S_AXI_WREADY;
  logic [1:0]             S_AXI_BRESP;
  logic                   S_AXI_BVALID;
  logic                   S_AXI_BREADY;
  logic [AddrWidth-1:0]   S_AXI_ARADDR;
  logic [2:0]             S_AXI_ARPROT;
  logic                   S_AXI_ARVALID;
  logic                   S_AXI_ARREADY;
  logic [DataWidth-1:0]   S_AXI_RDATA;
  logic [1:0]             S_AXI_RRESP;
  logic                   S_AXI_RVALID;
  logic                   S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/sdi_rx_axil_regs.sv
// AXI4-Lite register bank for the SDI RX subsystem: four RW control words, live status,
// frame counter and W1C error flags with a registered interrupt.
module sdi_rx_axil_regs #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  sdi_rx_axil_regs_if.slave                 s_axi,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   ctrl_o,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     status_i,
  input  logic                              frame_pulse_i,
  input  logic [1:0]                        err_pulse_i,
  output logic                              irq_o
);
  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;

  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d, bvalid_q, bvalid_d;
  logic [2:0]            aw_idx_q, aw_idx_d;
  logic [DW-1:0]         w_data_q, w_data_d;
  logic [3:0]            w_strb_q, w_strb_d;
  logic                  rvalid_q, rvalid_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic [3:0][DW-1:0]    ctrl_q, ctrl_d;
  logic [DW-1:0]         cnt_q, cnt_d;
  logic [1:0]            flags_q, flags_d, flags_clr;
  logic                  irq_q, irq_d;

  logic                  awready, wready, arready, aw_hs, w_hs, ar_hs, commit;
  logic [2:0]            wr_idx, ar_idx;
  logic [DW-1:0]         wr_data;
  logic [3:0]            wr_strb;

  assign awready = !aw_held_q && !bvalid_q;
  assign wready  = !w_held_q && !bvalid_q;
  assign arready = !rvalid_q;
  assign aw_hs   = s_axi.S_AXI_AWVALID && awready;
  assign w_hs    = s_axi.S_AXI_WVALID && wready;
  assign ar_hs   = s_axi.S_AXI_ARVALID && arready;
  assign ar_idx  = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  // A handshake this cycle counts as held, so the commit lands on the later handshake's edge.
  assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs) && !bvalid_q;
  assign wr_idx  = aw_held_q ? aw_idx_q : s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_data = w_held_q ? w_data_q : s_axi.S_AXI_WDATA;
  assign wr_strb = w_held_q ? w_strb_q : s_axi.S_AXI_WSTRB;

  always_comb begin
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = s_axi.S_AXI_WDATA;
      w_strb_d = s_axi.S_AXI_WSTRB;
    end
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
    end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    flags_clr = 2'b00;
    if (commit && !wr_idx[2]) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) ctrl_d[wr_idx[1:0]][8*b +: 8] = wr_data[8*b +: 8];
      end
    end
    if (commit && wr_idx == 3'd6 && wr_strb[0]) flags_clr = wr_data[1:0];
    // Hardware set is applied after the clear so a same-cycle pulse wins.
    flags_d = (flags_q & ~flags_clr) | err_pulse_i;
    cnt_d   = cnt_q + DW'(frame_pulse_i);
    irq_d   = |(flags_q & ctrl_q[3][1:0]);
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      case (ar_idx)
        3'd0, 3'd1, 3'd2, 3'd3: rdata_d = ctrl_q[ar_idx[1:0]];
        3'd4:                   rdata_d = status_i;
        3'd5:                   rdata_d = cnt_q;
        3'd6:                   rdata_d = {{(DW-2){1'b0}}, flags_q};
        default:                rdata_d = '0;
      endcase
    end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      ctrl_q    <= '0;
      cnt_q     <= '0;
      flags_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      ctrl_q    <= ctrl_d;
      cnt_q     <= cnt_d;
      flags_q   <= flags_d;
      irq_q     <= irq_d;
    end
  end

  assign s_axi.S_AXI_AWREADY = awready;
  assign s_axi.S_AXI_WREADY  = wready;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = arready;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign ctrl_o              = ctrl_q;
  assign irq_o               = irq_q;

  logic unused_in;
  assign unused_in = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};
endmodule

// File: tb/tb_sdi_rx_axil_regs.sv
// Directed bench for sdi_rx_axil_regs: a table of write/read vectors plus hand-written
// sequences for skew, backpressure, collisions, counter wrap, W1C/irq and reset.
module tb_sdi_rx_axil_regs;
  logic         clk;
  logic         rst_n;
  logic [127:0] ctrl;
  logic [31:0]  status;
  logic         frame_pulse;
  logic [1:0]   err_pulse;
  logic         irq;

  int n_vec;
  int n_fail;

  sdi_rx_axil_regs_if #(.AddrWidth(5), .DataWidth(32)) axi ();

  sdi_rx_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
    .ACLK          (clk),
    .ARESETN       (rst_n),
    .s_axi         (axi),
    .ctrl_o        (ctrl),
    .status_i      (status),
    .frame_pulse_i (frame_pulse),
    .err_pulse_i   (err_pulse),
    .irq_o         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, required finish before 400us");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          is_wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the B handshake.
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] err);
    bit aw_done, w_done, aw_fire, w_fire;
    int t;
    aw_done = 1'b0;
    w_done  = 1'b0;
    t       = 0;
    axi.S_AXI_AWADDR  = addr;
    axi.S_AXI_WDATA   = data;
    axi.S_AXI_WSTRB   = strb;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WVALID  = 1'b1;
    axi.S_AXI_BREADY  = 1'b1;
    err_pulse         = err;
    while (!(aw_done && w_done) && t < 20) begin
      aw_fire = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
      w_fire  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
      @(negedge clk);
      err_pulse = 2'b00;
      if (aw_fire) begin aw_done = 1'b1; axi.S_AXI_AWVALID = 1'b0; end
      if (w_fire)  begin w_done  = 1'b1; axi.S_AXI_WVALID  = 1'b0; end
      t++;
    end
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    check("wr_handshake", {aw_done, w_done}, 2'b11);
    check("wr_bvalid", axi.S_AXI_BVALID, 1'b1);
    check("wr_bresp", axi.S_AXI_BRESP, 2'b00);
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
    bit fired;
    int t;
    fired = 1'b0;
    t     = 0;
    axi.S_AXI_ARADDR  = addr;
    axi.S_AXI_ARVALID = 1'b1;
    axi.S_AXI_RREADY  = 1'b1;
    while (!fired && t < 20) begin
      fired = axi.S_AXI_ARREADY;
      @(negedge clk);
      t++;
    end
    axi.S_AXI_ARVALID = 1'b0;
    check("rd_handshake", fired, 1'b1);
    check("rd_rvalid", axi.S_AXI_RVALID, 1'b1);
    check("rd_rresp", axi.S_AXI_RRESP, 2'b00);
    data = axi.S_AXI_RDATA;
    @(negedge clk);
  endtask

  vec_t        vecs [20];
  logic [31:0] rd;
  int          nb;

  initial begin
    n_vec = 0;
    n_fail = 0;
    rst_n = 1'b0;
    status = 32'h1234_5678;
    frame_pulse = 1'b0;
    err_pulse = 2'b00;
    axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = 3'b0; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA = '0;  axi.S_AXI_WSTRB = '0;    axi.S_AXI_WVALID = 1'b0;
    axi.S_AXI_BREADY = 1'b1;
    axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = 3'b0; axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_RREADY = 1'b1;

    vecs[0]  = '{1'b1, 5'h00, 32'h1, 4'hF, 32'h0};
    vecs[1]  = '{1'b1, 5'h04, 32'h2, 4'hF, 32'h0};
    vecs[2]  = '{1'b1, 5'h08, 32'h3, 4'hF, 32'h0};
    vecs[3]  = '{1'b1, 5'h0C, 32'h4, 4'hF, 32'h0};
    vecs[4]  = '{1'b0, 5'h00, 32'h0, 4'h0, 32'h1};
    vecs[5]  = '{1'b0, 5'h04, 32'h0, 4'h0, 32'h2};
    vecs[6]  = '{1'b0, 5'h08, 32'h0, 4'h0, 32'h3};
    vecs[7]  = '{1'b0, 5'h0C, 32'h0, 4'h0, 32'h4};
    vecs[8]  = '{1'b1, 5'h10, 32'hDEAD_BEEF, 4'hF, 32'h0};
    vecs[9]  = '{1'b0, 5'h10, 32'h0, 4'h0, 32'h1234_5678};
    vecs[10] = '{1'b1, 5'h1C, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[11] = '{1'b0, 5'h1C, 32'h0, 4'h0, 32'h0};
    vecs[12] = '{1'b1, 5'h04, 32'hAABB_CCDD, 4'b0101, 32'h0};
    vecs[13] = '{1'b0, 5'h04, 32'h0, 4'h0, 32'h00BB_00DD};
    vecs[14] = '{1'b1, 5'h06, 32'h2, 4'hF, 32'h0};
    vecs[15] = '{1'b0, 5'h07, 32'h0, 4'h0, 32'h2};
    vecs[16] = '{1'b0, 5'h14, 32'h0, 4'h0, 32'h0};
    vecs[17] = '{1'b0, 5'h18, 32'h0, 4'h0, 32'h0};
    vecs[18] = '{1'b1, 5'h14, 32'h123, 4'hF, 32'h0};
    vecs[19] = '{1'b0, 5'h14, 32'h0, 4'h0, 32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 3'b111);
    check("rst_valid", {axi.S_AXI_BVALID, axi.S_AXI_RVALID, irq}, 3'b000);
    check("rst_rdata", axi.S_AXI_RDATA, 32'h0);
    check("rst_ctrl", ctrl, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 2'b00);
      end else begin
        axi_read(vecs[i].addr, rd);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
      end
    end
    check("ctrl_o_map", ctrl, {32'd4, 32'd3, 32'd2, 32'd1});

    // Same-cycle read and write of reg1: read sees the old value
    axi.S_AXI_AWADDR = 5'h04; axi.S_AXI_WDATA = 32'h99; axi.S_AXI_WSTRB = 4'hF;
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1;
    axi.S_AXI_ARADDR = 5'h04; axi.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0; axi.S_AXI_ARVALID = 1'b0;
    check("rw_coll_valid", {axi.S_AXI_BVALID, axi.S_AXI_RVALID}, 2'b11);
    check("rw_coll_old", axi.S_AXI_RDATA, 32'h2);
    @(negedge clk);
    axi_read(5'h04, rd);
    check("rw_coll_new", rd, 32'h99);

    // Flag set with irq disabled (reg3 = 4), WSTRB[0] gating of the clear
    err_pulse = 2'b10;
    @(negedge clk);
    err_pulse = 2'b00;
    @(negedge clk);
    check("irq_masked", irq, 1'b0);
    axi_read(5'h18, rd);
    check("flag1_set", rd, 32'h2);
    axi_write(5'h18, 32'h2, 4'b1110, 2'b00);
    axi_read(5'h18, rd);
    check("flag_clr_nostrb", rd, 32'h2);
    axi_write(5'h18, 32'h2, 4'b0001, 2'b00);
    axi_read(5'h18, rd);
    check("flag1_clr", rd, 32'h0);

    // W1C and irq
    axi_write(5'h0C, 32'h3, 4'hF, 2'b00);
    err_pulse = 2'b01;
    @(negedge clk);
    err_pulse = 2'b00;
    check("irq_plus1", irq, 1'b0);
    @(negedge clk);
    check("irq_plus2", irq, 1'b1);
    axi_write(5'h18, 32'h1, 4'hF, 2'b01);
    axi_read(5'h18, rd);
    check("w1c_set_wins", rd, 32'h1);
    check("w1c_irq_kept", irq, 1'b1);
    axi_write(5'h18, 32'h1, 4'hF, 2'b00);
    check("w1c_irq_clr", irq, 1'b0);
    axi_read(5'h18, rd);
    check("w1c_flags_clr", rd, 32'h0);

    // Channel skew: W leads AW, then AW leads W
    axi_write(5'h00, 32'h0, 4'hF, 2'b00);
    axi.S_AXI_WDATA = 32'hAABB_CCDD; axi.S_AXI_WSTRB = 4'b0010; axi.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    axi.S_AXI_WVALID = 1'b0;
    repeat (2) @(negedge clk);
    check("skew_w_held", {axi.S_AXI_WREADY, axi.S_AXI_BVALID}, 2'b00);
    axi.S_AXI_AWADDR = 5'h00; axi.S_AXI_AWVALID = 1'b1;
    @(negedge clk);
    axi.S_AXI_AWVALID = 1'b0;
    check("skew_w_bvalid", axi.S_AXI_BVALID, 1'b1);
    check("skew_w_reg0", ctrl[31:0], 32'h0000_CC00);
    @(negedge clk);
    check("skew_w_bdone", axi.S_AXI_BVALID, 1'b0);
    axi_write(5'h00, 32'h0, 4'hF, 2'b00);
    axi.S_AXI_AWADDR = 5'h00; axi.S_AXI_AWVALID = 1'b1;
    @(negedge clk);
    axi.S_AXI_AWVALID = 1'b0;
    repeat (2) @(negedge clk);
    check("skew_aw_held", {axi.S_AXI_AWREADY, axi.S_AXI_BVALID}, 2'b00);
    axi.S_AXI_WDATA = 32'hAABB_CCDD; axi.S_AXI_WSTRB = 4'b0010; axi.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    axi.S_AXI_WVALID = 1'b0;
    check("skew_aw_bvalid", axi.S_AXI_BVALID, 1'b1);
    check("skew_aw_reg0", ctrl[31:0], 32'h0000_CC00);
    @(negedge clk);

    // B backpressure: a second write presented during the stall must not be taken
    axi.S_AXI_BREADY = 1'b0;
    axi.S_AXI_AWADDR = 5'h08; axi.S_AXI_WDATA = 32'h55; axi.S_AXI_WSTRB = 4'hF;
    axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1;
    @(negedge clk);
    axi.S_AXI_WDATA = 32'h66;
    for (int i = 0; i < 5; i++) begin
      check("bstall_ready", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_BVALID}, 3'b001);
      @(negedge clk);
    end
    axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0; axi.S_AXI_BREADY = 1'b1;
    nb = 0;
    for (int i = 0; i < 4; i++) begin
      if (axi.S_AXI_BVALID && axi.S_AXI_BREADY) nb++;
      @(negedge clk);
    end
    check("bstall_once", nb, 1);
    check("bstall_reg2", ctrl[95:64], 32'h55);

    // R backpressure
    axi.S_AXI_RREADY = 1'b0;
    axi.S_AXI_ARADDR = 5'h08; axi.S_AXI_ARVALID = 1'b1;
    @(negedge clk);
    axi.S_AXI_ARADDR = 5'h00;
    for (int i = 0; i < 5; i++) begin
      check("rstall_hold", {axi.S_AXI_ARREADY, axi.S_AXI_RVALID, axi.S_AXI_RDATA},
            {1'b0, 1'b1, 32'h55});
      @(negedge clk);
    end
    axi.S_AXI_ARVALID = 1'b0; axi.S_AXI_RREADY = 1'b1;
    nb = 0;
    for (int i = 0; i < 4; i++) begin
      if (axi.S_AXI_RVALID && axi.S_AXI_RREADY) nb++;
      @(negedge clk);
    end
    check("rstall_once", nb, 1);

    // Frame counter: a few pulses, then wrap with a same-cycle read
    for (int i = 0; i < 3; i++) begin
      frame_pulse = 1'b1;
      @(negedge clk);
      frame_pulse = 1'b0;
      @(negedge clk);
    end
    axi_read(5'h14, rd);
    check("cnt_three", rd, 32'h3);
    force dut.cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.cnt_q;
    @(negedge clk);
    axi.S_AXI_ARADDR = 5'h14; axi.S_AXI_ARVALID = 1'b1; frame_pulse = 1'b1;
    check("cnt_ar_ready", axi.S_AXI_ARREADY, 1'b1);
    @(negedge clk);
    axi.S_AXI_ARVALID = 1'b0; frame_pulse = 1'b0;
    check("cnt_pre_wrap", {axi.S_AXI_RVALID, axi.S_AXI_RDATA}, {1'b1, 32'hFFFF_FFFF});
    @(negedge clk);
    axi_read(5'h14, rd);
    check("cnt_wrapped", rd, 32'h0);

    // Reset after AW handshake, before W
    axi.S_AXI_AWADDR = 5'h00; axi.S_AXI_AWVALID = 1'b1;
    @(negedge clk);
    axi.S_AXI_AWVALID = 1'b0;
    check("mid_aw_held", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY}, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 3'b111);
    check("mid_rst_valid", {axi.S_AXI_BVALID, axi.S_AXI_RVALID, irq}, 3'b000);
    check("mid_rst_ctrl", ctrl, 128'h0);
    check("mid_rst_rdata", axi.S_AXI_RDATA, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    axi_write(5'h00, 32'h5, 4'hF, 2'b00);
    check("post_rst_reg0", ctrl[31:0], 32'h5);
    nb = 0;
    for (int i = 0; i < 4; i++) begin
      if (axi.S_AXI_BVALID) nb++;
      @(negedge clk);
    end
    check("post_rst_no_extra_b", nb, 0);
    axi_read(5'h14, rd);
    check("post_rst_cnt", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/sdi_rx_axil_regs.md
# sdi_rx_axil_regs

AXI4-Lite slave register bank for the SDI RX subsystem. It is the responder the subsystem's S00_AXI port exposes to the processor or AXI VIP master. It holds four read/write control words, a read-only status word, a frame counter and a write-1-to-clear interrupt flag register. Each AXI4-Lite channel is handled independently with full VALID/READY backpressure.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 words.

- ACLK  in  1  clock; all logic is on the rising edge.
- ARESETN  in  1  reset, asynchronous and active-low.
- S_AXI_AWADDR  in  5  write address.
- S_AXI_AWPROT  in  3  write protection type; ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake.
- S_AXI_BRESP  out  2  write response; always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake.
- S_AXI_ARADDR  in  5  read address.
- S_AXI_ARPROT  in  3  read protection type; ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response; always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake.
- ctrl_o  out  4x32  contents of registers 0..3, flattened with reg0 at [31:0].
- status_i  in  32  live RX status, sampled on read.
- frame_pulse_i  in  1  one-cycle pulse per received frame.
- err_pulse_i  in  2  bit0 CRC error, bit1 lock loss; one-cycle pulses.
- irq_o  out  1  OR of (flags AND irq enable).

## Operation
- Word index is AWADDR[4:2] or ARADDR[4:2]; bits [1:0] are ignored.
- Register map:
  - 0..3: RW control words. reg3[1:0] is the irq enable.
  - 4: status_i, read-only.
  - 5: frame counter, read-only. Increments on frame_pulse_i and wraps from 0xFFFFFFFF to 0.
  - 6: flags[1:0], W1C. Set by err_pulse_i, cleared by writing 1 to the bit.
  - 7: reserved. Reads 0; writes are ignored.
- Every response is OKAY, including writes to read-only or reserved words; those writes have no effect.
- WSTRB applies per byte to registers 0..3. For register 6, only WDATA[1:0] with WSTRB[0] clears flags.
- Write path states:
  - Address and data latches are independent. AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
  - AW or W may arrive first, or both in the same cycle.
  - When aw_held && w_held && !BVALID, the write commits in that cycle: the register updates, both held bits clear and BVALID goes to 1.
  - BVALID clears on BVALID && BREADY.
- Read path: ARREADY = !RVALID. On an AR handshake, RDATA is registered from the map and RVALID goes to 1. RVALID clears on RVALID && RREADY.
- Read and write paths are independent and may complete in the same cycle.
- Same-cycle collisions:
  - A read of a word being written in the same cycle returns the old value.
  - A hardware set and a W1C clear of the same flag bit: set wins.
  - frame_pulse_i during a read of register 5 returns the pre-increment value.
- irq_o is registered: irq_o = |(flags & reg3[1:0]), one cycle after flags change.

## Timing
- Reset (ARESETN=0, asynchronous):
  - All registers, counter, flags and held bits are 0.
  - BVALID=0, RVALID=0, RDATA=0, irq_o=0.
  - AWREADY=1, WREADY=1, ARREADY=1 (combinational from cleared state).
- Write latency: with AW and W both valid in cycle N, handshake in N, commit and BVALID=1 in N+1. With BREADY=1, BVALID drops in N+2. Throughput is one write per 2 cycles.
- Read latency: AR handshake in cycle N, RVALID=1 with data in N+1.
- While BVALID is stalled by BREADY=0, no further AW or W is accepted.
- While RVALID is stalled by RREADY=0, RDATA is held stable and ARREADY=0.
- Reset asserted mid-transaction discards any held AW or W and any pending B or R response. No response is issued for it.

## Test plan
- Sequential write then read: write 0x1, 0x2, 0x3, 0x4 to addresses 0x0, 0x4, 0x8, 0xC, then read them back -> data matches, all BRESP/RRESP = 00, ctrl_o = {4,3,2,1}.
- Channel skew: W valid 3 cycles before AW, and separately AW 3 cycles before W, with WSTRB=4'b0010 and data 0xAABBCCDD on reg0 preloaded with 0 -> reg0 = 0x0000CC00, BVALID asserts one cycle after the later handshake.
- Backpressure: BREADY=0 for 5 cycles, then RREADY=0 for 5 cycles -> AWREADY, WREADY and ARREADY stay 0 and RDATA stays stable while stalled. Each response completes exactly once.
- Counter wrap and collision: preload the counter to 0xFFFFFFFF via 0xFFFFFFFF frame pulses (or a force), then pulse frame_pulse_i in the same cycle as the AR for 0x14 -> read returns 0xFFFFFFFF and the next read returns 0x0.
- W1C interrupt:
  - reg3 = 0x3; pulse err_pulse_i = 2'b01 -> irq_o=1 two cycles later.
  - Write 0x1 to 0x18 in the same cycle as err_pulse_i[0] -> flag stays 1.
  - Write 0x1 to 0x18 again with no pulse -> flags = 0 and irq_o = 0 the next cycle.
- Reset mid-write: assert ARESETN=0 after the AW handshake but before W -> all outputs return to reset values. A subsequent write to 0x0 of 0x5 -> reg0 = 0x5 with a single BVALID.
